// File: rtl/ahb3lite_host_master.sv
// ahb3lite_host_master: turns host FIFO command packets into single AHB3-lite transfers and streams back status plus read data
module ahb3lite_host_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        BUSY,
  output logic        RDEN,
  input  logic        RDEMPTY,
  input  logic [7:0]  RDDATA,
  output logic        WREN,
  input  logic        WRFULL,
  output logic [7:0]  WRDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
  typedef enum logic [2:0] {CMD, ADDR, DATA, CHECK, APHASE, DPHASE, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] size, lane;
  logic wr, rd_v, field_done, mis, reject, unused_cmd;
  logic [31:0] addr, wdata, rdata;
  logic [2:0] status, req, got, idx, need, n_bytes, n_resp;
  logic [4:0] sh;
  assign unused_cmd = ^{RDDATA[7:4], RDDATA[2]};
  assign HBURST = 3'b000;
  assign HPROT = HPROT_VAL;
  // req counts bytes requested in the current field, got counts bytes captured
  always_comb begin
    n_bytes = size == 2'd0 ? 3'd1 : size == 2'd1 ? 3'd2 : 3'd4;
    need = state == CMD ? 3'd1 : state == ADDR ? 3'd4 : state == DATA ? n_bytes : 3'd0;
    RDEN = ~RDEMPTY & (req < need);
    field_done = rd_v & (got == need - 3'd1);
    mis = size == 2'd1 ? addr[0] : size == 2'd2 ? |addr[1:0] : 1'b0;
    reject = (size == 2'd3) | mis;
    sh = size == 2'd0 ? {addr[1:0], 3'b000} : size == 2'd1 ? {addr[1], 4'b0000} : 5'd0;
    n_resp = wr ? 3'd1 : n_bytes + 3'd1;
    lane = idx[1:0] - 2'd1;
    BUSY = (state != CMD) | (req != 3'd0);
    state_nx = state;
    case (state)
      CMD:     state_nx = field_done ? ADDR : CMD;
      ADDR:    state_nx = field_done ? (wr ? DATA : CHECK) : ADDR;
      DATA:    state_nx = field_done ? CHECK : DATA;
      CHECK:   state_nx = reject ? RESP : APHASE;
      APHASE:  state_nx = HREADY ? DPHASE : APHASE;
      DPHASE:  state_nx = HREADY ? RESP : DPHASE;
      RESP:    state_nx = (~WRFULL & (idx == n_resp - 3'd1)) ? CMD : RESP;
      default: state_nx = CMD;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= CMD;
      size <= '0;
      wr <= 1'b0;
      addr <= '0;
      wdata <= '0;
      rdata <= '0;
      status <= '0;
      req <= '0;
      got <= '0;
      idx <= '0;
      rd_v <= 1'b0;
      WREN <= 1'b0;
      WRDATA <= '0;
      HADDR <= '0;
      HTRANS <= 2'b00;
      HWRITE <= 1'b0;
      HSIZE <= '0;
      HWDATA <= '0;
    end else begin
      state <= state_nx;
      rd_v <= RDEN;
      req <= field_done ? 3'd0 : req + {2'b00, RDEN};
      got <= field_done ? 3'd0 : got + {2'b00, rd_v};
      WREN <= 1'b0;
      if (rd_v && state == CMD) begin
        size <= RDDATA[1:0];
        wr <= RDDATA[3];
        wdata <= '0;
      end
      if (rd_v && state == ADDR) addr[{got[1:0], 3'b000} +: 8] <= RDDATA;
      if (rd_v && state == DATA) wdata[{got[1:0], 3'b000} +: 8] <= RDDATA;
      if (state == CHECK) begin
        status <= {size == 2'd3, mis, 1'b0};
        HADDR <= addr;
        HWRITE <= wr;
        HSIZE <= {1'b0, size};
        HWDATA <= wdata << sh;
        HTRANS <= reject ? 2'b00 : 2'b10;
        idx <= '0;
      end
      if (state == APHASE && HREADY) HTRANS <= 2'b00;
      if (state == DPHASE && HREADY) begin
        status[0] <= HRESP;
        rdata <= HRDATA >> sh;
      end
      if (state == RESP && !WRFULL) begin
        WREN <= 1'b1;
        WRDATA <= idx == 3'd0 ? {5'b00000, status} : |status ? 8'h00 : rdata[{lane, 3'b000} +: 8];
        idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_ahb3lite_host_master.sv
// tb_ahb3lite_host_master: host FIFO + AHB slave models around the bridge, table vectors plus randomized packets
module tb_ahb3lite_host_master;
  logic CLK = 1'b0, RESET = 1'b1;
  logic BUSY, RDEN, RDEMPTY, WREN, WRFULL, HWRITE, HREADY, HRESP;
  logic [7:0] RDDATA, WRDATA;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  logic [3:0] HPROT;

  ahb3lite_host_master dut (
    .CLK(CLK), .RESET(RESET), .BUSY(BUSY), .RDEN(RDEN), .RDEMPTY(RDEMPTY), .RDDATA(RDDATA),
    .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] c;
    logic [31:0] a, wd, rd;
    int err;
    bit ex;
    logic [31:0] ehw;
    int en;
    logic [39:0] er;
  } vec_t;
  typedef struct {
    logic [31:0] a;
    logic w;
    logic [2:0] s;
    logic [31:0] wd;
  } xfer_t;

  logic [7:0] in_q[$], out_q[$];
  xfer_t xq[$];
  vec_t tbl[8];
  int checks = 0, errors = 0;
  int ws = 0, err_mode = 0, cyc = 0, bad_bus = 0, overrd = 0, full_left = 0;
  int aidx = 0, didx = 0, t_rd = -1, t_wr = -1;
  bit tog_mode = 0, rnd_mode = 0, full_rnd = 0, full_arm = 0, rden_prev = 0, dp = 0;
  logic [31:0] cur_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // host FIFO and AHB slave; inputs change on the falling edge, registered outputs are stable there
  initial begin
    RDEMPTY = 1'b1; RDDATA = '0; WRFULL = 1'b0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (RESET) begin
        dp = 0; aidx = 0; didx = 0; rden_prev = 0;
      end else begin
        if (rden_prev) begin
          if (in_q.size() > 0) RDDATA = in_q.pop_front();
          else overrd++;
        end
        if (WREN) begin
          out_q.push_back(WRDATA);
          if (t_wr < 0) t_wr = cyc;
          if (full_arm) begin full_left = 5; full_arm = 0; end
        end
        if (dp) begin
          if (HTRANS != 2'b00) bad_bus++;
          HREADY = (didx == ws + err_mode);
          HRESP = (err_mode != 0) && (didx >= ws);
          HRDATA = cur_rd;
          if (HREADY) begin
            xq[xq.size() - 1].wd = HWDATA;
            dp = 0; didx = 0;
          end else didx++;
        end else if (HTRANS == 2'b10) begin
          HRESP = 1'b0;
          HREADY = (aidx == ws);
          if (HREADY) begin
            xq.push_back('{a: HADDR, w: HWRITE, s: HSIZE, wd: 32'h0});
            dp = 1; aidx = 0;
          end else aidx++;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0;
        end
      end
      RDEMPTY = (in_q.size() == 0) || (tog_mode && (cyc % 2) == 1) || (rnd_mode && ($urandom % 2) == 1);
      WRFULL = (full_left > 0) || (full_rnd && ($urandom % 3) == 0);
      if (full_left > 0) full_left--;
      #1;
      rden_prev = RDEN & ~RESET;
      if (RDEN && t_rd < 0) t_rd = cyc;
    end
  end

  task automatic push_pkt(input logic [7:0] c, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = c[1:0] == 2'd0 ? 1 : c[1:0] == 2'd1 ? 2 : 4;
    in_q.push_back(c);
    for (int i = 0; i < 4; i++) in_q.push_back(a[8*i +: 8]);
    if (c[3]) for (int i = 0; i < n; i++) in_q.push_back(wd[8*i +: 8]);
  endtask

  task automatic do_pkt(input string nm, input vec_t v);
    int k;
    logic [7:0] b;
    xfer_t x;
    k = 0;
    while (out_q.size() < v.en && k < 2000) begin @(posedge CLK); #1; k++; end
    repeat (3) begin @(posedge CLK); #1; end
    chk({nm, " resp_len"}, out_q.size(), v.en);
    for (int i = 0; i < v.en; i++) begin
      b = out_q.size() > 0 ? out_q.pop_front() : 8'hxx;
      chk($sformatf("%s resp%0d", nm, i), {24'h0, b}, {24'h0, v.er[8*i +: 8]});
    end
    out_q.delete();
    chk({nm, " xfers"}, xq.size(), {31'h0, v.ex});
    if (xq.size() > 0) begin
      x = xq.pop_front();
      chk({nm, " haddr"}, x.a, v.a);
      chk({nm, " hwrite"}, {31'h0, x.w}, {31'h0, v.c[3]});
      chk({nm, " hsize"}, {29'h0, x.s}, {30'h0, v.c[1:0]});
      if (v.c[3]) chk({nm, " hwdata"}, x.wd, v.ehw);
    end
    xq.delete();
    chk({nm, " idle_after_aphase"}, bad_bus, 0);
    chk({nm, " overread"}, overrd, 0);
  endtask

  function automatic vec_t model(input logic [7:0] c, input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rd, input int er);
    vec_t v;
    int sz, n, off, st;
    logic [31:0] mask;
    sz = int'(c[1:0]);
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    st = (sz == 3 ? 4 : 0) + (((sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)) ? 2 : 0);
    off = (sz >= 2) ? 0 : int'(a % 4) - int'(a % 4) % n;
    v.c = c; v.a = a; v.wd = wd; v.rd = rd; v.err = er;
    v.ex = (st == 0);
    if (v.ex && er != 0) st += 1;
    mask = n == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 32'h1;
    v.ehw = (wd & mask) << (8 * off);
    v.en = c[3] ? 1 : n + 1;
    v.er = 40'(st);
    if (!c[3] && st == 0)
      for (int i = 0; i < n; i++) v.er = v.er | (40'((rd >> (8 * (off + i))) & 32'hFF) << (8 * (i + 1)));
    return v;
  endfunction

  initial begin
    vec_t v, v2;
    int k;
    tbl[0] = '{c: 8'h0A, a: 32'h2000_1000, wd: 32'hDEAD_BEEF, rd: 32'h0, err: 0, ex: 1, ehw: 32'hDEAD_BEEF, en: 1, er: 40'h00};
    tbl[1] = '{c: 8'h00, a: 32'h4000_0003, wd: 32'h0, rd: 32'h5A00_0000, err: 0, ex: 1, ehw: 32'h0, en: 2, er: 40'h5A00};
    tbl[2] = '{c: 8'h01, a: 32'h4000_0002, wd: 32'h0, rd: 32'h1234_5678, err: 1, ex: 1, ehw: 32'h0, en: 3, er: 40'h000001};
    tbl[3] = '{c: 8'h09, a: 32'h0000_0006, wd: 32'h0000_BEEF, rd: 32'h0, err: 0, ex: 1, ehw: 32'hBEEF_0000, en: 1, er: 40'h00};
    tbl[4] = '{c: 8'h01, a: 32'h0000_0002, wd: 32'h0, rd: 32'hAABB_CCDD, err: 0, ex: 1, ehw: 32'h0, en: 3, er: 40'hAABB00};
    tbl[5] = '{c: 8'h03, a: 32'h0000_0001, wd: 32'h0, rd: 32'hFFFF_FFFF, err: 0, ex: 0, ehw: 32'h0, en: 5, er: 40'h04};
    tbl[6] = '{c: 8'hF6, a: 32'h0000_0100, wd: 32'h0, rd: 32'h1122_3344, err: 0, ex: 1, ehw: 32'h0, en: 5, er: 40'h11_2233_4400};
    tbl[7] = '{c: 8'h08, a: 32'h0000_0001, wd: 32'h0000_0077, rd: 32'h0, err: 0, ex: 1, ehw: 32'h0000_7700, en: 1, er: 40'h00};

    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst htrans", {30'h0, HTRANS}, 0);
    chk("rst haddr", HADDR, 0);
    chk("rst hwrite", {31'h0, HWRITE}, 0);
    chk("rst hsize", {29'h0, HSIZE}, 0);
    chk("rst hwdata", HWDATA, 0);
    chk("rst wrdata", {24'h0, WRDATA}, 0);
    chk("rst hburst", {29'h0, HBURST}, 0);
    chk("rst hprot", {28'h0, HPROT}, 32'h3);
    chk("rst wren", {31'h0, WREN}, 0);
    chk("rst busy", {31'h0, BUSY}, 0);
    chk("rst rden", {31'h0, RDEN}, 0);

    for (int i = 0; i < 8; i++) begin
      cur_rd = tbl[i].rd; err_mode = tbl[i].err;
      push_pkt(tbl[i].c, tbl[i].a, tbl[i].wd);
      do_pkt($sformatf("vec%0d", i), tbl[i]);
    end
    err_mode = 0;

    // rejected write must still swallow its data bytes so the next packet parses
    v = '{c: 8'h0A, a: 32'h2, wd: 32'h0102_0304, rd: 32'h0, err: 0, ex: 0, ehw: 32'h0, en: 1, er: 40'h02};
    v2 = '{c: 8'h02, a: 32'h8, wd: 32'h0, rd: 32'hCAFE_F00D, err: 0, ex: 1, ehw: 32'h0, en: 5, er: 40'hCA_FEF0_0D00};
    cur_rd = v2.rd;
    push_pkt(v.c, v.a, v.wd);
    push_pkt(v2.c, v2.a, v2.wd);
    do_pkt("misaligned", v);
    do_pkt("after_misaligned", v2);

    t_rd = -1; t_wr = -1; cur_rd = tbl[1].rd;
    push_pkt(tbl[1].c, tbl[1].a, tbl[1].wd);
    do_pkt("latency_pkt", tbl[1]);
    chk("read latency", t_wr - t_rd, 11);

    tog_mode = 1; ws = 3;
    for (int i = 0; i < 2; i++) begin
      cur_rd = tbl[i].rd; full_arm = 1;
      push_pkt(tbl[i].c, tbl[i].a, tbl[i].wd);
      do_pkt($sformatf("flow%0d", i), tbl[i]);
    end
    tog_mode = 0; full_arm = 0; full_left = 0;

    rnd_mode = 1; full_rnd = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      ws = int'($urandom % 3);
      err_mode = ($urandom % 4 == 0) ? 1 : 0;
      cur_rd = $urandom;
      v = model(8'($urandom), a, $urandom, cur_rd, err_mode);
      push_pkt(v.c, v.a, v.wd);
      do_pkt($sformatf("rnd%0d", i), v);
    end
    rnd_mode = 0; full_rnd = 0; err_mode = 0;

    ws = 4; cur_rd = 32'h5555_AAAA;
    push_pkt(8'h02, 32'h10, 32'h0);
    k = 0;
    while (!dp && k < 200) begin @(posedge CLK); #1; k++; end
    chk("dphase reached", {31'h0, dp}, 1);
    chk("busy before reset", {31'h0, BUSY}, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("mid rst htrans", {30'h0, HTRANS}, 0);
    chk("mid rst busy", {31'h0, BUSY}, 0);
    chk("mid rst wren", {31'h0, WREN}, 0);
    RESET = 1'b0;
    in_q.delete(); out_q.delete(); xq.delete();
    ws = 0; cur_rd = tbl[4].rd;
    push_pkt(tbl[4].c, tbl[4].a, tbl[4].wd);
    do_pkt("post_reset", tbl[4]);
    chk("in_q drained", in_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end
endmodule
